// File: rtl/shift_add_mult_4bit_if.sv
// ----------------------------------------------------------------------------
// shift_add_mult_4bit_if
// Request/result bundle for the 4x4 shift-and-add multiplier.
//   start   : request to begin a multiply (sampled on rising clk)
//   a, b    : unsigned multiplicand / multiplier, captured on accepted start
//   busy    : operation in progress
//   done    : one-cycle pulse, product newly valid
//   product : registered 8-bit result, holds last completed value
// Modports: master drives the request, slave (the multiplier) drives results.
// ----------------------------------------------------------------------------
interface shift_add_mult_4bit_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_mult_4bit.sv
// ----------------------------------------------------------------------------
// fullAdder_4bit
// 4-bit ripple-carry adder built from per-bit full-adder equations.
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : 4-bit sum
//   cout_o   : carry out
// ----------------------------------------------------------------------------
module fullAdder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic carry;

    always_comb begin
        sum_o = '0;
        carry = cin_i;
        for (int unsigned i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

// ----------------------------------------------------------------------------
// shift_add_mult_4bit
// Sequential unsigned 4x4 -> 8 multiplier, one shift-and-add step per clock.
// IDLE accepts start, RUN performs four add/shift steps, DONE pulses done for
// one cycle and returns to IDLE.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of shift_add_mult_4bit_if (start/a/b in,
//          busy/done/product out)
// ----------------------------------------------------------------------------
module shift_add_mult_4bit (
    input  logic                        clk,
    input  logic                        rst,
    shift_add_mult_4bit_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e     state_q,   state_d;
    logic [3:0] mcand_q,   mcand_d;
    logic [3:0] mplr_q,    mplr_d;
    logic [7:0] acc_q,     acc_d;
    logic [1:0] count_q,   count_d;
    logic [7:0] product_q, product_d;

    logic [3:0]  addend;
    logic [3:0]  sum;
    logic        cout;
    logic [12:0] step;
    logic [7:0]  acc_step;
    logic [3:0]  mplr_step;

    // Partial-product add: upper accumulator nibble plus the multiplicand
    // when the current multiplier bit is set.
    assign addend = mplr_q[0] ? mcand_q : '0;

    fullAdder_4bit u_add (
        .a_i    (acc_q[7:4]),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // {cout, sum, acc[3:0], mplr} shifted right by one: carry lands in acc[7],
    // sum in acc[6:3], and the low accumulator bits drift down into mplr.
    assign step      = {cout, sum, acc_q[3:0], mplr_q} >> 1;
    assign acc_step  = step[11:4];
    assign mplr_step = step[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    mplr_d  = bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                mplr_d  = mplr_step;
                count_d = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    state_d   = DONE;
                    // Each step's sum[0] enters acc[3] and reaches acc[0]
                    // after the remaining steps, so after the fourth step the
                    // complete 8-bit product sits in the accumulator.
                    product_d = acc_step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status decoded purely from the state register.
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_mult_4bit.sv
module tb_shift_add_mult_4bit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    shift_add_mult_4bit_if ifc ();

    shift_add_mult_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts clock edges since an accepted request.
    // Edge of acceptance -> 1, product appears after the 5th edge count,
    // idle again one edge later. Result computed with plain arithmetic.
    // ------------------------------------------------------------------
    int         m_phase = 0;
    int         acc_cnt = 0;
    logic [7:0] m_pend  = '0;
    logic [7:0] m_prod  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_prod  <= '0;
        end else if (m_phase == 0) begin
            if (ifc.start) begin
                m_phase <= 1;
                m_pend  <= {4'b0, ifc.a} * {4'b0, ifc.b};
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            m_phase <= (m_phase == 5) ? 0 : m_phase + 1;
            if (m_phase == 4) m_prod <= m_pend;
        end
    end

    logic prev_done = 1'b0;

    always @(negedge clk) begin
        chk("cyc_busy", 32'(ifc.busy), 32'(m_phase != 0));
        chk("cyc_done", 32'(ifc.done), 32'(m_phase == 5));
        chk("cyc_product", 32'(ifc.product), 32'(m_prod));
        chk("cyc_done_consec", 32'(ifc.done & prev_done), 32'd0);
        prev_done <= ifc.done;
    end

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_idle();
        int n;
        n = 0;
        while (ifc.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 32'(ifc.busy), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string tag);
        int n;
        bit seen;
        wait_idle();
        ifc.a     = a;
        ifc.b     = b;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        seen = 1'b0;
        n    = 1;
        while (n <= 20 && !seen) begin
            if (ifc.done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, n, 32'd5);
            chk({tag, "_product"}, 32'(ifc.product), 32'(exp));
            @(negedge clk);
            chk({tag, "_busy_after"}, 32'(ifc.busy), 32'd0);
            chk({tag, "_done_after"}, 32'(ifc.done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         w;
        int         prev;
        bit         seen;
        logic [7:0] v;

        vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'd143};
        vecs[1] = '{a: 4'd0,  b: 4'd15, p: 8'd0};
        vecs[2] = '{a: 4'd15, b: 4'd0,  p: 8'd0};
        vecs[3] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
        vecs[4] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        vecs[5] = '{a: 4'd9,  b: 4'd6,  p: 8'd54};

        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;

        // Reset: asynchronous effect before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_async_busy", 32'(ifc.busy), 32'd0);
        chk("rst_async_done", 32'(ifc.done), 32'd0);
        chk("rst_async_product", 32'(ifc.product), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First start after reset release is accepted normally
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Held start, operand change during RUN, earliest restart at E6
        wait_idle();
        ifc.a = 4'd3; ifc.b = 4'd5; ifc.start = 1'b1;
        @(negedge clk);
        ifc.a = 4'd7; ifc.b = 4'd7;
        n = 1; seen = 1'b0;
        while (n <= 20 && !seen) begin
            if (ifc.done) seen = 1'b1;
            else begin @(negedge clk); n++; end
        end
        chk("hold_first_latency", n, 32'd5);
        chk("hold_first_product", 32'(ifc.product), 32'd15);
        n = 0; seen = 1'b0;
        while (n <= 20 && !seen) begin
            @(negedge clk);
            n++;
            if (ifc.done) seen = 1'b1;
        end
        chk("hold_second_gap", n, 32'd6);
        chk("hold_second_product", 32'(ifc.product), 32'd49);
        ifc.start = 1'b0;
        wait_idle();

        // Asynchronous reset in the third RUN cycle
        ifc.a = 4'd9; ifc.b = 4'd9; ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(ifc.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_product", 32'(ifc.product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(ifc.done), 32'd0);
        end
        run_op(4'd6, 4'd7, 8'd42, "after_abort");

        // Randomized traffic, held/dropped start, operand churn
        for (int k = 0; k < 30; k++) begin
            int hold;
            int gap;
            hold = $urandom_range(1, 8);
            gap  = $urandom_range(0, 3);
            ifc.start = 1'b1;
            for (int j = 0; j < hold; j++) begin
                ifc.a = 4'($urandom);
                ifc.b = 4'($urandom);
                @(negedge clk);
            end
            ifc.start = 1'b0;
            for (int j = 0; j < gap; j++) @(negedge clk);
        end
        wait_idle();

        // Exhaustive back-to-back at earliest acceptance
        ifc.start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v     = 8'(i);
            ifc.a = v[7:4];
            ifc.b = v[3:0];
            prev  = acc_cnt;
            w     = 0;
            while (acc_cnt == prev && w < 12) begin
                @(negedge clk);
                w++;
            end
            chk("exh_accept", 32'(acc_cnt != prev), 32'd1);
            chk("exh_gap", w, (i == 0) ? 32'd1 : 32'd6);
        end
        ifc.start = 1'b0;
        wait_idle();
        chk("exh_last_product", 32'(ifc.product), 32'd225);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
